// File: rtl/sort_engine.sv
// ============================================================================
// sort_engine : loads N unsigned words, odd-even transposition sort, drains largest-first
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_engine #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [7:0]   swap_cnt
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    swap_cnt_q, swap_cnt_d;
  logic [4:0]    phase_swaps;
  logic [8:0]    swap_sum;

  assign in_ready  = (state_q == S_LOAD) && !rst;
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = (state_q == S_DRAIN) ? mem_q[rd_idx_q[AW-1:0]] : '0;
  assign busy      = (state_q == S_SORT);
  assign swap_cnt  = swap_cnt_q;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_idx_d    = wr_idx_q;
    phase_d     = phase_q;
    rd_idx_d    = rd_idx_q;
    swap_cnt_d  = swap_cnt_q;
    phase_swaps = '0;
    swap_sum    = '0;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          mem_d[wr_idx_q[AW-1:0]] = in_data;
          wr_idx_d = wr_idx_q + CW'(1);
          if (wr_idx_q == LAST) begin
            state_d    = S_SORT;
            phase_d    = '0;
            swap_cnt_d = '0;
          end
        end
      end

      S_SORT: begin
        // Pairs of one parity never overlap, so every cell reads the old array.
        for (int i = 0; i < N - 1; i++) begin
          if ((i[0] == phase_q[0]) && (mem_q[i+1] > mem_q[i])) begin
            mem_d[i]    = mem_q[i+1];
            mem_d[i+1]  = mem_q[i];
            phase_swaps = phase_swaps + 5'd1;
          end
        end
        swap_sum   = {1'b0, swap_cnt_q} + 9'(phase_swaps);
        swap_cnt_d = swap_sum[8] ? 8'hFF : swap_sum[7:0];
        if (phase_q == LAST) begin
          state_d  = S_DRAIN;
          rd_idx_d = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST) begin
            state_d  = S_LOAD;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      wr_idx_q   <= '0;
      phase_q    <= '0;
      rd_idx_q   <= '0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      phase_q    <= phase_d;
      rd_idx_q   <= rd_idx_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // Storage needs no reset: a block is always fully written before it is read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_sort_engine.sv
// ============================================================================
// tb_sort_engine : directed self-checking bench for sort_engine (N=8, W=8)
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sort_engine;

  localparam int N = 8;
  localparam int W = 8;

  typedef logic [W-1:0] blk_t [N];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic [7:0]   swap_cnt;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  sort_engine #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input blk_t v, input bit toggle, output int hs_cyc);
    int g;
    hs_cyc = 0;
    for (int k = 0; k < N; k++) begin
      if (toggle) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = v[k];
      #1;
      g = 0;
      while (!in_ready && g < 20) begin
        tick();
        g++;
      end
      check($sformatf("load_ready_%0d", k), 32'(in_ready), 32'd1);
      hs_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sort(input int hs_cyc, input int exp_swaps);
    int g;
    int busy_n;
    int ir_bad;
    g = 0;
    busy_n = 0;
    ir_bad = 0;
    while (!out_valid && g < 40) begin
      if (busy) busy_n++;
      if (in_ready) ir_bad++;
      tick();
      g++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
    check("first_out_latency", 32'(cyc - hs_cyc), 32'd9);
    check("busy_cycles", 32'(busy_n), 32'd8);
    check("in_ready_during_sort", 32'(ir_bad), 32'd0);
    check("swap_cnt", 32'(swap_cnt), 32'(exp_swaps));
  endtask

  task automatic drain(input blk_t e, input int stall_at, input int exp_swaps);
    int g;
    logic [W-1:0] held;
    for (int k = 0; k < N; k++) begin
      g = 0;
      while (!out_valid && g < 20) begin
        tick();
        g++;
      end
      if (k == stall_at) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_data", 32'(out_data), 32'(held));
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      check($sformatf("out_data_%0d", k), 32'(out_data), 32'(e[k]));
      check($sformatf("drain_in_ready_%0d", k), 32'(in_ready), 32'd0);
      if (k == N - 1) check("swap_cnt_held", 32'(swap_cnt), 32'(exp_swaps));
      tick();
    end
    check("post_drain_in_ready", 32'(in_ready), 32'd1);
    check("post_drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    blk_t blk_rev, exp_rev, blk_srt, blk_dup, exp_dup, blk_alt, exp_alt, blk_mix, exp_mix;
    int   hs;

    blk_rev = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    exp_rev = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    blk_srt = '{8'd200, 8'd150, 8'd100, 8'd90, 8'd80, 8'd40, 8'd20, 8'd0};
    blk_dup = '{8'd255, 8'd0, 8'd255, 8'd7, 8'd7, 8'd0, 8'd128, 8'd255};
    exp_dup = '{8'd255, 8'd255, 8'd255, 8'd128, 8'd7, 8'd7, 8'd0, 8'd0};
    blk_alt = '{8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd1};
    exp_alt = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1};
    blk_mix = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    exp_mix = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_swap_cnt", 32'(swap_cnt), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);

    // Reverse order: every pair is an inversion.
    load_block(blk_rev, 1'b0, hs);
    wait_sort(hs, 28);
    drain(exp_rev, -1, 28);

    // Already ranked: nothing moves.
    load_block(blk_srt, 1'b0, hs);
    wait_sort(hs, 0);
    drain(blk_srt, -1, 0);

    // Duplicates/extremes with gappy input and a 5-cycle output stall.
    load_block(blk_dup, 1'b1, hs);
    wait_sort(hs, 12);
    drain(exp_dup, 3, 12);

    // Reset during SORT phase 3 abandons the block.
    load_block(blk_rev, 1'b0, hs);
    tick();
    tick();
    tick();
    check("mid_sort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_sort_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    check("after_rst_out_valid", 32'(out_valid), 32'd0);
    check("after_rst_busy", 32'(busy), 32'd0);
    check("after_rst_swap_cnt", 32'(swap_cnt), 32'd0);

    load_block(blk_alt, 1'b0, hs);
    wait_sort(hs, 6);
    drain(exp_alt, -1, 6);

    // Back-to-back: next block starts on the cycle right after the last drain handshake.
    load_block(blk_mix, 1'b0, hs);
    wait_sort(hs, 14);
    drain(exp_mix, -1, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Sequential sorter for blocks of N unsigned bytes.
- Loads a block over a valid/ready input stream and sorts it in place with odd-even transposition, using N/2 parallel compare-swap cells with strict greater-than and larger value kept.
- Streams the block out largest-first over a valid/ready output stream.
- Sits downstream of byte producers and feeds ranked data to display/selection logic.

Parameters:
- N, 8, entries per block; even, 2..16.
- W, 8, data width in bits, unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data valid this cycle.
- in_data  input  W  unsigned input byte.
- in_ready  output  1  sorter accepts in_data this cycle.
- out_valid  output  1  out_data valid this cycle.
- out_data  output  W  current sorted element.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high while in SORT state.
- swap_cnt  output  8  number of swaps performed on current block; saturates at 255.

Behaviour:
- Storage: mem[0..N-1] of W bits. Counters: wr_idx, phase, rd_idx, each clog2(N)+1 bits.
- Reset, when rst=1 at a clock edge:
  - state=LOAD; wr_idx=phase=rd_idx=0; swap_cnt=0.
  - mem contents are don't-care.
  - In the cycle after the reset edge: out_valid=0, busy=0, in_ready=1.
  - While rst is high, in_ready is forced to 0.
- Reset mid-operation in any state abandons the block. No partial output is emitted afterwards.
- Combinational outputs:
  - in_ready = (state==LOAD) and not rst.
  - out_valid = (state==DRAIN).
  - out_data = mem[rd_idx] while in DRAIN, else 0.
  - busy = (state==SORT).
- LOAD state:
  - On in_valid and in_ready: mem[wr_idx] = in_data, then wr_idx++.
  - When the N-th byte is accepted (wr_idx==N-1 with a handshake): next state=SORT, phase=0, swap_cnt=0.
  - in_valid while in_ready=0 is ignored; the producer must hold its data.
- SORT state:
  - Exactly N cycles, one phase per cycle.
  - Even phase: compare pairs (0,1), (2,3), ….
  - Odd phase: compare pairs (1,2), (3,4), … up to (N-3,N-2).
  - For each pair (i,i+1): if mem[i+1] > mem[i], swap them. Equal values are never swapped, so sorting is stable by arrival order.
  - swap_cnt += number of swaps in that phase, saturating at 255.
  - After phase N-1: next state=DRAIN, rd_idx=0.
  - Latency from the last input handshake to the first out_valid is N+1 cycles.
- DRAIN state:
  - On out_valid and out_ready: rd_idx++.
  - After the handshake with rd_idx==N-1: next state=LOAD, wr_idx=0.
  - out_data is held stable while out_ready=0.
  - in_ready stays 0 throughout DRAIN; loading never overlaps draining.
- Arithmetic:
  - Comparisons are unsigned, W bits.
  - Counters never exceed N. Indices wrap to 0 only via explicit state transitions.
- swap_cnt holds its value through DRAIN. It clears on entry to SORT or on reset.
- Result guarantee: out_data over the N DRAIN handshakes is non-increasing.

Test Plan:
- Reverse-order input. Send 1,2,3,4,5,6,7,8 with out_ready=1 → outputs 8,7,6,5,4,3,2,1. swap_cnt=28. First out_valid exactly 9 cycles after the last in handshake.
- Already-sorted input. Send 200,150,100,90,80,40,20,0 → identical order out; swap_cnt=0; busy high for exactly 8 cycles.
- Duplicates and extremes. Send 255,0,255,7,7,0,128,255 → outputs 255,255,255,128,7,7,0,0.
- Backpressure on both sides:
  - in_valid toggled every other cycle during LOAD; all 8 bytes are captured.
  - out_ready low for 5 cycles mid-DRAIN; out_data is stable and no element is dropped or repeated.
  - in_ready=0 for the entire SORT and DRAIN period.
- Reset mid-operation. Assert rst for 1 cycle during SORT phase 3 → next cycle state=LOAD, in_ready=1, out_valid=0, swap_cnt=0. A following block 9,1,9,1,9,1,9,1 sorts to 9,9,9,9,1,1,1,1.
- Back-to-back blocks. A second block is loaded immediately after the last DRAIN handshake → in_ready=1 the next cycle; the second block sorts independently of the first.
